// File: rtl/class_vote_filter_if.sv
// Bus between the argmax source/sinks and class_vote_filter.
// The master drives the control and raw class; the slave (filter) drives the filtered result.
interface class_vote_filter_if;
    logic        i_en;
    logic        i_clear;
    logic [1:0]  i_class_in;
    logic        o_sample_tick;
    logic [1:0]  o_class_out;
    logic        o_class_valid;
    logic        o_class_change;
    logic [15:0] o_change_count;
    logic [63:0] o_hist_flat;

    modport master (
        output i_en, i_clear, i_class_in,
        input  o_sample_tick, o_class_out, o_class_valid, o_class_change,
               o_change_count, o_hist_flat
    );

    modport slave (
        input  i_en, i_clear, i_class_in,
        output o_sample_tick, o_class_out, o_class_valid, o_class_change,
               o_change_count, o_hist_flat
    );
endinterface

// File: rtl/class_vote_filter.sv
// Temporal majority-vote filter for the 2-bit argmax class: prescaled sampling into a sliding window.
// Optional per-class sample histogram is built when CLASS_VOTE_HIST_EN is defined.
module class_vote_filter #(
    parameter int SAMPLE_DIV  = 1000,
    parameter int WINDOW_LOG2 = 3,
    parameter int THRESH      = 5
) (
    input  logic               clk,
    input  logic               rst,
    class_vote_filter_if.slave bus
);
    localparam int              WINDOW    = 1 << WINDOW_LOG2;
    localparam int              VW        = WINDOW_LOG2 + 1;
    localparam logic [15:0]     DIV_LAST  = 16'(SAMPLE_DIV - 1);
    localparam logic [VW-1:0]   THRESH_V  = VW'(THRESH);
    localparam logic [VW-1:0]   FILL_LAST = VW'(WINDOW - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0]            r_presc;
    logic                   w_tick;
    state_t                 r_state;
    logic [WINDOW_LOG2-1:0] r_ptr;
    logic [VW-1:0]          r_fill;
    logic [1:0]             r_buf   [WINDOW];
    logic [VW-1:0]          r_votes [4];
    logic [1:0]             w_old;
    logic [3:0]             w_inc;
    logic [3:0]             w_dec;
    logic                   w_hit;
    logic [1:0]             w_hit_class;
    logic [1:0]             r_class_out;
    logic                   r_class_valid;
    logic                   r_class_change;
    logic [15:0]            r_change_count;

    // A tick is lost if en drops or clear/rst is asserted in the same cycle.
    assign w_tick = ~rst & ~bus.i_clear & bus.i_en & (r_presc == DIV_LAST);
    assign w_old  = r_buf[r_ptr];

    // Sample prescaler, frozen while disabled.
    always_ff @(posedge clk) begin
        if (rst || bus.i_clear) begin
            r_presc <= 16'd0;
        end else if (bus.i_en) begin
            r_presc <= (r_presc == DIV_LAST) ? 16'd0 : r_presc + 16'd1;
        end else begin
            r_presc <= r_presc;
        end
    end

    // Per-class vote increments/decrements for this tick.
    always_comb begin
        w_inc = 4'd0;
        w_dec = 4'd0;
        if (w_tick) begin
            if (r_state == ST_FILL) begin
                w_inc[bus.i_class_in] = 1'b1;
            end else if (w_old != bus.i_class_in) begin
                w_inc[bus.i_class_in] = 1'b1;
                w_dec[w_old]          = 1'b1;
            end else begin
                w_inc = 4'd0;
            end
        end else begin
            w_dec = 4'd0;
        end
    end

    // Window FSM: fills WINDOW samples, then replaces the oldest entry per tick.
    always_ff @(posedge clk) begin
        if (rst || bus.i_clear) begin
            r_state <= ST_FILL;
            r_ptr   <= '0;
            r_fill  <= '0;
            for (int k = 0; k < 4; k++) r_votes[k] <= '0;
            for (int i = 0; i < WINDOW; i++) r_buf[i] <= 2'd0;
        end else if (w_tick) begin
            r_buf[r_ptr] <= bus.i_class_in;
            r_ptr        <= r_ptr + WINDOW_LOG2'(1);
            for (int k = 0; k < 4; k++) begin
                r_votes[k] <= r_votes[k] + VW'(w_inc[k]) - VW'(w_dec[k]);
            end
            case (r_state)
                ST_FILL: begin
                    r_fill <= r_fill + VW'(1);
                    if (r_fill == FILL_LAST) r_state <= ST_RUN;
                    else                     r_state <= ST_FILL;
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_FILL;
            endcase
        end
    end

    // THRESH exceeds half the window, so at most one class can hit.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_class = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (r_votes[k] >= THRESH_V) begin
                w_hit       = 1'b1;
                w_hit_class = 2'(k);
            end else begin
                w_hit       = w_hit;
                w_hit_class = w_hit_class;
            end
        end
    end

    // Decision register, one cycle behind the vote counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_class_out    <= 2'd0;
            r_class_valid  <= 1'b0;
            r_class_change <= 1'b0;
            r_change_count <= 16'd0;
        end else if (bus.i_clear) begin
            r_class_out    <= 2'd0;
            r_class_valid  <= 1'b0;
            r_class_change <= 1'b0;
        end else if (bus.i_en) begin
            if ((r_state == ST_RUN) && w_hit) begin
                r_class_out   <= w_hit_class;
                r_class_valid <= 1'b1;
                if (!r_class_valid || (w_hit_class != r_class_out)) begin
                    r_class_change <= 1'b1;
                    r_change_count <= sat_inc16(r_change_count);
                end else begin
                    r_class_change <= 1'b0;
                end
            end else begin
                r_class_valid  <= 1'b0;
                r_class_change <= 1'b0;
            end
        end else begin
            r_class_change <= 1'b0;
        end
    end

    assign bus.o_sample_tick  = w_tick;
    assign bus.o_class_out    = r_class_out;
    assign bus.o_class_valid  = r_class_valid;
    assign bus.o_class_change = r_class_change;
    assign bus.o_change_count = r_change_count;

`ifdef CLASS_VOTE_HIST_EN
    logic [15:0] r_hist [4];

    // Per-class sample histogram; survives clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) r_hist[k] <= 16'd0;
        end else if (w_tick) begin
            r_hist[bus.i_class_in] <= sat_inc16(r_hist[bus.i_class_in]);
        end
    end

    assign bus.o_hist_flat = {r_hist[3], r_hist[2], r_hist[1], r_hist[0]};
`else
    assign bus.o_hist_flat = 64'd0;
`endif
endmodule

// File: tb/tb_class_vote_filter.sv
// Bench for class_vote_filter: directed phase table plus randomized traffic against a
// sliding-window reference model (SAMPLE_DIV=4, window 8, threshold 5).
module tb_class_vote_filter;
    localparam int DIV = 4;
    localparam int WL  = 3;
    localparam int WIN = 8;
    localparam int TH  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    class_vote_filter_if bus();

    class_vote_filter #(.SAMPLE_DIV(DIV), .WINDOW_LOG2(WL), .THRESH(TH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ticks_seen;

    // Reference model state
    int         m_presc = 0;
    logic [1:0] q[$];
    logic [1:0] m_out    = 2'd0;
    logic       m_valid  = 1'b0;
    logic       m_change = 1'b0;
    int         m_count  = 0;
    int         m_hist [4] = '{0, 0, 0, 0};

    typedef struct packed {
        logic        en;
        logic        clr;
        logic [1:0]  cls;
        logic [7:0]  n;
        logic [3:0]  ex_ticks;
        logic        ex_valid;
        logic [1:0]  ex_out;
        logic        ex_change;
        logic [15:0] ex_count;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic majority(output logic [1:0] c);
        int cnt [4] = '{0, 0, 0, 0};
        c = 2'd0;
        if (q.size() != WIN) return 1'b0;
        foreach (q[i]) cnt[q[i]]++;
        for (int k = 0; k < 4; k++) begin
            if (cnt[k] >= TH) begin
                c = 2'(k);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void add(input logic en, input logic clr, input logic [1:0] cls,
                                input int n, input int tk, input logic v, input logic [1:0] o,
                                input logic ch, input int cnt);
        vec_t r;
        r.en = en; r.clr = clr; r.cls = cls; r.n = 8'(n); r.ex_ticks = 4'(tk);
        r.ex_valid = v; r.ex_out = o; r.ex_change = ch; r.ex_count = 16'(cnt);
        vt.push_back(r);
    endfunction

    // One clock cycle: drive, check the tick strobe, advance the model, check registered outputs.
    task automatic step(input logic en, input logic clr, input logic [1:0] cls);
        logic       exp_tick;
        logic       mh;
        logic [1:0] mc;
        logic [63:0] exp_hist;
        bus.i_en = en;
        bus.i_clear = clr;
        bus.i_class_in = cls;
        #1;
        exp_tick = !rst && !clr && en && (m_presc == DIV - 1);
        chk("sample_tick", 64'(bus.o_sample_tick), 64'(exp_tick));
        if (bus.o_sample_tick) ticks_seen++;
        if (rst) begin
            m_presc = 0; q.delete(); m_out = 2'd0; m_valid = 1'b0; m_change = 1'b0;
            m_count = 0; m_hist = '{0, 0, 0, 0};
        end else if (clr) begin
            m_presc = 0; q.delete(); m_out = 2'd0; m_valid = 1'b0; m_change = 1'b0;
        end else if (en) begin
            mh = majority(mc);
            if (mh) begin
                m_change = !m_valid || (mc != m_out);
                if (m_change && m_count < 65535) m_count++;
                m_out = mc;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_change = 1'b0;
            end
            if (exp_tick) begin
                q.push_back(cls);
                if (q.size() > WIN) void'(q.pop_front());
                if (m_hist[cls] < 65535) m_hist[cls]++;
            end
            m_presc = (m_presc == DIV - 1) ? 0 : m_presc + 1;
        end else begin
            m_change = 1'b0;
        end
        @(posedge clk);
        #1;
`ifdef CLASS_VOTE_HIST_EN
        exp_hist = {16'(m_hist[3]), 16'(m_hist[2]), 16'(m_hist[1]), 16'(m_hist[0])};
`else
        exp_hist = 64'd0;
`endif
        chk("class_out",    64'(bus.o_class_out),    64'(m_out));
        chk("class_valid",  64'(bus.o_class_valid),  64'(m_valid));
        chk("class_change", 64'(bus.o_class_change), 64'(m_change));
        chk("change_count", 64'(bus.o_change_count), 64'(m_count));
        chk("hist_flat",    bus.o_hist_flat,         exp_hist);
    endtask

    initial begin
        logic [1:0] cur;
        logic [1:0] cls;
        // en, clr, cls, cycles, ticks, valid, out, change, count
        add(1'b1, 1'b0, 2'd2, 32, 8, 1'b0, 2'd0, 1'b0, 0);   // fill with class 2
        add(1'b1, 1'b0, 2'd2,  1, 0, 1'b1, 2'd2, 1'b1, 1);   // first decision
        add(1'b1, 1'b0, 2'd2,  1, 0, 1'b1, 2'd2, 1'b0, 1);
        add(1'b0, 1'b0, 2'd1, 50, 0, 1'b1, 2'd2, 1'b0, 1);   // frozen, prescaler at 2
        add(1'b1, 1'b0, 2'd2,  1, 0, 1'b1, 2'd2, 1'b0, 1);
        add(1'b1, 1'b0, 2'd2,  1, 1, 1'b1, 2'd2, 1'b0, 1);   // tick 2 cycles after re-enable
        add(1'b1, 1'b0, 2'd1, 16, 4, 1'b1, 2'd2, 1'b0, 1);   // 4 ticks of class 1
        add(1'b1, 1'b0, 2'd1,  1, 0, 1'b0, 2'd2, 1'b0, 1);   // 4/4 split
        add(1'b1, 1'b0, 2'd1,  3, 1, 1'b0, 2'd2, 1'b0, 1);   // 5th tick
        add(1'b1, 1'b0, 2'd1,  1, 0, 1'b1, 2'd1, 1'b1, 2);
        add(1'b1, 1'b0, 2'd1,  1, 0, 1'b1, 2'd1, 1'b0, 2);
        for (int r = 0; r < 8; r++) begin                     // alternate 0/3
            add(1'b1, 1'b0, (r % 2 == 0) ? 2'd0 : 2'd3, 4, 1,
                (r < 3) ? 1'b1 : 1'b0, 2'd1, 1'b0, 2);
        end
        add(1'b1, 1'b0, 2'd1, 19, 5, 1'b1, 2'd1, 1'b1, 3);   // 5 ticks of class 1
        add(1'b1, 1'b1, 2'd1,  1, 0, 1'b0, 2'd0, 1'b0, 3);   // clear
        add(1'b1, 1'b0, 2'd1, 32, 8, 1'b0, 2'd0, 1'b0, 3);   // refill
        add(1'b1, 1'b0, 2'd1,  1, 0, 1'b1, 2'd1, 1'b1, 4);

        bus.i_en = 1'b0;
        bus.i_clear = 1'b0;
        bus.i_class_in = 2'd0;
        rst = 1'b1;
        step(1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 2'd0);
        chk("reset.class_valid",  64'(bus.o_class_valid),  64'd0);
        chk("reset.change_count", 64'(bus.o_change_count), 64'd0);
        chk("reset.hist_flat",    bus.o_hist_flat,         64'd0);
        rst = 1'b0;

        foreach (vt[i]) begin
            ticks_seen = 0;
            for (int c = 0; c < int'(vt[i].n); c++) step(vt[i].en, vt[i].clr, vt[i].cls);
            chk($sformatf("vec%0d.ticks", i),  64'(ticks_seen),            64'(vt[i].ex_ticks));
            chk($sformatf("vec%0d.valid", i),  64'(bus.o_class_valid),     64'(vt[i].ex_valid));
            chk($sformatf("vec%0d.out", i),    64'(bus.o_class_out),       64'(vt[i].ex_out));
            chk($sformatf("vec%0d.change", i), 64'(bus.o_class_change),    64'(vt[i].ex_change));
            chk($sformatf("vec%0d.count", i),  64'(bus.o_change_count),    64'(vt[i].ex_count));
        end

        cur = 2'($urandom_range(3, 0));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(59, 0) == 0) cur = 2'($urandom_range(3, 0));
            cls = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 0)) : cur;
            step($urandom_range(9, 0) != 0, $urandom_range(299, 0) == 0, cls);
        end

        rst = 1'b1;
        step(1'b1, 1'b0, cur);
        step(1'b1, 1'b0, cur);
        chk("midreset.change_count", 64'(bus.o_change_count), 64'd0);
        chk("midreset.class_out",    64'(bus.o_class_out),    64'd0);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, cur);
        chk("post_reset.valid", 64'(bus.o_class_valid), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
